// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, two-flop column synchroniser, per-frame
// single-key detection and a frame-rate press/release debounce FSM.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [4:0] HEX_key,
  output logic       key_pressed_signal,
  output logic [1:0] scan_state
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  state_t          state;
  logic [3:0]      col_meta, col_sync;
  logic [SW-1:0]   slot_cnt;
  logic [1:0]      row_idx;
  logic            acc_hit, acc_multi;
  logic [3:0]      acc_key;
  logic [3:0]      cand;
  logic [CW-1:0]   deb_cnt;

  logic [3:0]      low_cols;
  logic [1:0]      samp_col;
  logic            samp_one, samp_many;
  logic            frame_hit, frame_multi, frame_valid;
  logic [3:0]      frame_key;
  logic            slot_end, frame_end;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Fold the current row sample into the running frame result so the frame-end
  // edge sees all four rows without an extra cycle of latency.
  always_comb begin
    low_cols  = ~col_sync;
    samp_col  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (low_cols[i]) samp_col = 2'(i);
    end
    samp_one    = (low_cols != 4'd0) && ((low_cols & (low_cols - 4'd1)) == 4'd0);
    samp_many   = (low_cols != 4'd0) && !samp_one;
    frame_multi = acc_multi || samp_many || (acc_hit && samp_one);
    frame_hit   = acc_hit || samp_one;
    frame_key   = samp_one ? key_code(row_idx, samp_col) : acc_key;
    frame_valid = frame_hit && !frame_multi;
    slot_end    = (slot_cnt == SLOT_LAST);
    frame_end   = slot_end && (row_idx == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      col_meta  <= 4'hF;
      col_sync  <= 4'hF;
      slot_cnt  <= '0;
      row_idx   <= 2'd0;
      row_n     <= 4'b1110;
      acc_hit   <= 1'b0;
      acc_multi <= 1'b0;
      acc_key   <= 4'h0;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
      if (slot_end) begin
        slot_cnt <= '0;
        row_idx  <= row_idx + 2'd1;
        row_n    <= ~(4'b0001 << (row_idx + 2'd1));
        if (row_idx == 2'd3) begin
          acc_hit   <= 1'b0;
          acc_multi <= 1'b0;
          acc_key   <= 4'h0;
        end else begin
          acc_hit   <= frame_hit;
          acc_multi <= frame_multi;
          acc_key   <= frame_key;
        end
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  // A different key seen while held or releasing only counts as "not cand";
  // the new key must then debounce from IDLE.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state              <= IDLE;
      cand               <= 4'h0;
      deb_cnt            <= '0;
      HEX_key            <= 5'h1F;
      key_pressed_signal <= 1'b0;
    end else if (frame_end) begin
      case (state)
        IDLE: begin
          if (frame_valid) begin
            cand    <= frame_key;
            deb_cnt <= CW'(1);
            state   <= PRESS_CHK;
          end
        end
        PRESS_CHK: begin
          if (!frame_valid) begin
            state <= IDLE;
          end else if (frame_key != cand) begin
            cand    <= frame_key;
            deb_cnt <= CW'(1);
          end else if (deb_cnt + CW'(1) == CNT_DONE) begin
            deb_cnt            <= deb_cnt + CW'(1);
            HEX_key            <= {1'b0, cand};
            key_pressed_signal <= 1'b1;
            state              <= HELD;
          end else begin
            deb_cnt <= deb_cnt + CW'(1);
          end
        end
        HELD: begin
          if (!(frame_valid && frame_key == cand)) begin
            deb_cnt <= CW'(1);
            state   <= REL_CHK;
          end
        end
        default: begin
          if (frame_valid && frame_key == cand) begin
            state <= HELD;
          end else if (deb_cnt + CW'(1) == CNT_DONE) begin
            deb_cnt            <= deb_cnt + CW'(1);
            key_pressed_signal <= 1'b0;
            state              <= IDLE;
          end else begin
            deb_cnt <= deb_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign scan_state = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: per-frame vector table plus hand-written
// reset and row-stepping sequences, with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int FRAME        = 4 * SCAN_DIV;
  localparam int NVEC         = 33;

  logic       clk;
  logic       clear_n;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [4:0] HEX_key;
  logic       key_pressed_signal;
  logic [1:0] scan_state;
  logic [15:0] keys;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] keys;
    logic [1:0]  exp_state;
    logic        exp_kp;
    logic [4:0]  exp_hex;
  } vec_t;

  vec_t vecs [NVEC];

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk               (clk),
    .clear_n           (clear_n),
    .col_n             (col_n),
    .row_n             (row_n),
    .HEX_key           (HEX_key),
    .key_pressed_signal(key_pressed_signal),
    .scan_state        (scan_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key (r,c) is bit r*4+c of keys; a closed key shorts its column to a driven-low row.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] k);
    keys = k;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_row_n"}, int'(row_n), 'hE);
    checkOutput({tag, "_hex"}, int'(HEX_key), 'h1F);
    checkOutput({tag, "_kp"}, int'(key_pressed_signal), 0);
    checkOutput({tag, "_state"}, int'(scan_state), 0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    keys    = 16'h0000;
    clear_n = 1'b0;

    // clean press/release of key 6 at (1,2)
    vecs[0]  = '{16'h0040, 2'd1, 1'b0, 5'h1F};
    vecs[1]  = '{16'h0040, 2'd1, 1'b0, 5'h1F};
    vecs[2]  = '{16'h0040, 2'd2, 1'b1, 5'h06};
    vecs[3]  = '{16'h0040, 2'd2, 1'b1, 5'h06};
    vecs[4]  = '{16'h0040, 2'd2, 1'b1, 5'h06};
    vecs[5]  = '{16'h0040, 2'd2, 1'b1, 5'h06};
    vecs[6]  = '{16'h0000, 2'd3, 1'b1, 5'h06};
    vecs[7]  = '{16'h0000, 2'd3, 1'b1, 5'h06};
    vecs[8]  = '{16'h0000, 2'd0, 1'b0, 5'h06};
    // bounce on key 5
    vecs[9]  = '{16'h0020, 2'd1, 1'b0, 5'h06};
    vecs[10] = '{16'h0000, 2'd0, 1'b0, 5'h06};
    vecs[11] = '{16'h0020, 2'd1, 1'b0, 5'h06};
    vecs[12] = '{16'h0000, 2'd0, 1'b0, 5'h06};
    // two keys in row 0 together
    vecs[13] = '{16'h0003, 2'd0, 1'b0, 5'h06};
    vecs[14] = '{16'h0003, 2'd0, 1'b0, 5'h06};
    vecs[15] = '{16'h0003, 2'd0, 1'b0, 5'h06};
    vecs[16] = '{16'h0003, 2'd0, 1'b0, 5'h06};
    vecs[17] = '{16'h0003, 2'd0, 1'b0, 5'h06};
    // roll from E (3,0) directly to D (3,3)
    vecs[18] = '{16'h1000, 2'd1, 1'b0, 5'h06};
    vecs[19] = '{16'h1000, 2'd1, 1'b0, 5'h06};
    vecs[20] = '{16'h1000, 2'd2, 1'b1, 5'h0E};
    vecs[21] = '{16'h8000, 2'd3, 1'b1, 5'h0E};
    vecs[22] = '{16'h8000, 2'd3, 1'b1, 5'h0E};
    vecs[23] = '{16'h8000, 2'd0, 1'b0, 5'h0E};
    vecs[24] = '{16'h8000, 2'd1, 1'b0, 5'h0E};
    vecs[25] = '{16'h8000, 2'd1, 1'b0, 5'h0E};
    vecs[26] = '{16'h8000, 2'd2, 1'b1, 5'h0D};
    // release D, then accept 9 at (2,2)
    vecs[27] = '{16'h0000, 2'd3, 1'b1, 5'h0D};
    vecs[28] = '{16'h0000, 2'd3, 1'b1, 5'h0D};
    vecs[29] = '{16'h0000, 2'd0, 1'b0, 5'h0D};
    vecs[30] = '{16'h0400, 2'd1, 1'b0, 5'h0D};
    vecs[31] = '{16'h0400, 2'd1, 1'b0, 5'h0D};
    vecs[32] = '{16'h0400, 2'd2, 1'b1, 5'h09};

    repeat (2) waitEdge();
    checkReset("reset");
    applyStimulus(vecs[0].keys);
    @(negedge clk);
    clear_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].keys);
      for (int e = 1; e <= FRAME; e++) begin
        waitEdge();
        if (i == 0) begin
          checkOutput($sformatf("row_step_e%0d", e), int'(row_n),
                      int'(~(4'b0001 << ((e / SCAN_DIV) % 4)) & 4'hF));
        end
      end
      checkOutput($sformatf("v%0d_state", i), int'(scan_state), int'(vecs[i].exp_state));
      checkOutput($sformatf("v%0d_kp", i), int'(key_pressed_signal), int'(vecs[i].exp_kp));
      checkOutput($sformatf("v%0d_hex", i), int'(HEX_key), int'(vecs[i].exp_hex));
    end

    // reset pulse mid-frame while 9 is held
    repeat (5) waitEdge();
    @(negedge clk);
    clear_n = 1'b0;
    waitEdge();
    checkReset("held_reset");
    @(negedge clk);
    clear_n = 1'b1;
    for (int e = 1; e <= 3 * FRAME; e++) begin
      waitEdge();
      if (e == 1) checkOutput("rst_restart_row", int'(row_n), 'hE);
      if (e == FRAME) checkOutput("rst_f1_state", int'(scan_state), 1);
      if (e == 3 * FRAME - 1) begin
        checkOutput("rst_pre_kp", int'(key_pressed_signal), 0);
        checkOutput("rst_pre_hex", int'(HEX_key), 'h1F);
      end
      if (e == 3 * FRAME) begin
        checkOutput("rst_acc_kp", int'(key_pressed_signal), 1);
        checkOutput("rst_acc_hex", int'(HEX_key), 'h09);
        checkOutput("rst_acc_state", int'(scan_state), 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
